// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// controller state type, the default bus-phase timeout and a helper that
// classifies requests the unit refuses to put on the bus.
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } lsu_state_e;

    // Illegal size encoding, or an access that does not sit on its natural
    // boundary.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// -----------------------------------------------------------------------------
// lsu_byte_lane
// Purely combinational lane steering for the load/store unit.
//   word_i        : word read from memory (old word for stores, load source)
//   store_data_i  : right-aligned store data
//   size_i        : SZ_BYTE / SZ_HALF / SZ_WORD
//   addr_lo_i     : byte offset within the word
//   unsigned_i    : zero-extend sub-word loads when set
//   merged_o      : word_i with the store lane(s) replaced by store_data_i
//   load_data_o   : selected lane of word_i, sign or zero extended
// -----------------------------------------------------------------------------
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] store_data_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                case (addr_lo_i)
                    2'd0:    merged_o[7:0]   = store_data_i[7:0];
                    2'd1:    merged_o[15:8]  = store_data_i[7:0];
                    2'd2:    merged_o[23:16] = store_data_i[7:0];
                    default: merged_o[31:24] = store_data_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo_i[1]) begin
                    merged_o[31:16] = store_data_i[15:0];
                end else begin
                    merged_o[15:0] = store_data_i[15:0];
                end
            end
            SZ_WORD: merged_o = store_data_i;
            default: merged_o = word_i;
        endcase
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        case (size_i)
            SZ_BYTE: load_data_o = unsigned_i ? {24'b0, byte_sel}
                                              : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data_o = unsigned_i ? {16'b0, half_sel}
                                              : {{16{half_sel[15]}}, half_sel};
            default: load_data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-stage load/store controller between execute and a word-wide data
// memory bus. Accepts one request at a time, holds the bus stable while the
// memory stretches a phase with mem_ready, stalls the pipeline while busy,
// extracts/extends sub-word loads and turns sub-word stores into a
// read-modify-write because the memory only writes whole words.
//
// Ports
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata
//                         : request side, req_ready high only when idle
//   rsp_valid/rsp_rdata/rsp_error : one-cycle completion pulse + result
//   stall                 : high whenever the unit is not idle
//   mem_A/mem_WE/mem_WD   : word-aligned bus outputs (0 when not in a phase)
//   mem_RD/mem_ready/mem_error : bus inputs, mem_error valid with mem_ready
//
// Optional feature macro: LSU_TIMEOUT_EN
//   When defined, a bus phase that waits TIMEOUT_CYCLES cycles for mem_ready
//   is abandoned and the request completes with rsp_error = 1.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        stall,
    output logic [31:0] mem_A,
    output logic        mem_WE,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD,
    input  logic        mem_ready,
    input  logic        mem_error
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] merged_q, merged_d;

    logic [31:0] lane_merged;
    logic [31:0] lane_load;

`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [CNT_W-1:0] unused_timeout_cfg;
    assign unused_timeout_cfg = CNT_W'(TIMEOUT_CYCLES);
`endif

    lsu_byte_lane u_lane (
        .word_i       (mem_RD),
        .store_data_i (wdata_q),
        .size_i       (size_q),
        .addr_lo_i    (addr_q[1:0]),
        .unsigned_i   (uns_q),
        .merged_o     (lane_merged),
        .load_data_o  (lane_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            merged_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            merged_q <= merged_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        merged_d = merged_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (req_is_bad(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!req_we || req_size == SZ_WORD) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    err_d   = mem_error;
                    rdata_d = (we_q || mem_error) ? '0 : lane_load;
                    state_d = ST_RESP;
                end
            end
            ST_RMW_RD: begin
                if (mem_ready) begin
                    if (mem_error) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        merged_d = lane_merged;
                        state_d  = ST_RMW_WR;
`ifdef LSU_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end
                end
            end
            ST_RMW_WR: begin
                if (mem_ready) begin
                    err_d   = mem_error;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef LSU_TIMEOUT_EN
        // The last waiting cycle is the one where the counter would reach
        // TIMEOUT_CYCLES; abandon the phase so RESP follows immediately.
        if ((state_q == ST_ACCESS || state_q == ST_RMW_RD || state_q == ST_RMW_WR)
            && !mem_ready) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                cnt_d   = '0;
                err_d   = 1'b1;
                rdata_d = '0;
                state_d = ST_RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    // Bus outputs are derived from the latched request only, so they cannot
    // move while a phase is stretched by mem_ready.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        stall     = (state_q != ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
        rsp_error = (state_q == ST_RESP) && err_q;
        mem_A     = '0;
        mem_WE    = 1'b0;
        mem_WD    = '0;
        case (state_q)
            ST_ACCESS: begin
                mem_A  = {addr_q[31:2], 2'b00};
                mem_WE = we_q;
                mem_WD = we_q ? wdata_q : '0;
            end
            ST_RMW_RD: begin
                mem_A = {addr_q[31:2], 2'b00};
            end
            ST_RMW_WR: begin
                mem_A  = {addr_q[31:2], 2'b00};
                mem_WE = 1'b1;
                mem_WD = merged_q;
            end
            default: ;
        endcase
    end

endmodule
